// File: rtl/bus_dma_pkg.sv
// Shared types and constants for the bus_dma block-copy initiator.
// Copy-only build by default; defining BUS_DMA_FILL_EN adds the pattern-fill mode.
package bus_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_DONE
    } state_t;

    localparam logic [3:0]  BE_FULL    = 4'hf;
    localparam int          WORD_BYTES = 4;
    // Clears the byte-offset bits so every bus address is word aligned.
    localparam logic [31:0] ADDR_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/bus_dma.sv
// Word-by-word memory copy engine on the mem_cmd/mem_rsp bus; one outstanding read.
// Optional macro BUS_DMA_FILL_EN adds fill/fill_pattern ports for a write-only pattern fill.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int LEN_BITS    = 16,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic                start,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [LEN_BITS-1:0] len_words,
`ifdef BUS_DMA_FILL_EN
    input  logic                fill,
    input  logic [31:0]         fill_pattern,
`endif
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                mem_cmd_valid,
    input  logic                mem_cmd_ready,
    output logic                mem_cmd_wr,
    output logic                mem_cmd_instr,
    output logic [31:0]         mem_cmd_addr,
    output logic [31:0]         mem_cmd_wdata,
    output logic [3:0]          mem_cmd_be,
    input  logic                mem_rsp_ready,
    input  logic [31:0]         mem_rsp_rdata
);

    localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);

    state_t              state_reg, state_next;
    logic [31:0]         src_cur_reg, src_cur_next;
    logic [31:0]         dst_cur_reg, dst_cur_next;
    logic [LEN_BITS-1:0] remaining_reg, remaining_next;
    logic [31:0]         data_reg, data_next;
    logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic                err_reg, err_next;
`ifdef BUS_DMA_FILL_EN
    logic                fill_reg, fill_next;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg     <= ST_IDLE;
            src_cur_reg   <= '0;
            dst_cur_reg   <= '0;
            remaining_reg <= '0;
            data_reg      <= '0;
            tmo_cnt_reg   <= '0;
            err_reg       <= 1'b0;
`ifdef BUS_DMA_FILL_EN
            fill_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            src_cur_reg   <= src_cur_next;
            dst_cur_reg   <= dst_cur_next;
            remaining_reg <= remaining_next;
            data_reg      <= data_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            err_reg       <= err_next;
`ifdef BUS_DMA_FILL_EN
            fill_reg      <= fill_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        src_cur_next   = src_cur_reg;
        dst_cur_next   = dst_cur_reg;
        remaining_next = remaining_reg;
        data_next      = data_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        err_next       = err_reg;
`ifdef BUS_DMA_FILL_EN
        fill_next      = fill_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    src_cur_next   = src_addr & ADDR_MASK;
                    dst_cur_next   = dst_addr & ADDR_MASK;
                    remaining_next = len_words;
                    err_next       = 1'b0;
                    tmo_cnt_next   = '0;
                    state_next     = (len_words == '0) ? ST_DONE : ST_RD_REQ;
`ifdef BUS_DMA_FILL_EN
                    fill_next = fill;
                    if (fill) begin
                        data_next = fill_pattern;
                        if (len_words != '0) state_next = ST_WR_REQ;
                    end
`endif
                end
            end
            ST_RD_REQ: begin
                if (mem_cmd_ready) begin
                    tmo_cnt_next = '0;
                    state_next   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rsp_ready) begin
                    data_next  = mem_rsp_rdata;
                    state_next = ST_WR_REQ;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    // Abort on the cycle the count reaches the limit; no write follows.
                    if (tmo_cnt_reg == TMO_W'(RSP_TIMEOUT - 1)) begin
                        err_next   = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_WR_REQ: begin
                if (mem_cmd_ready) begin
                    src_cur_next   = src_cur_reg + 32'(WORD_BYTES);
                    dst_cur_next   = dst_cur_reg + 32'(WORD_BYTES);
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == LEN_BITS'(1)) begin
                        state_next = ST_DONE;
                    end else begin
`ifdef BUS_DMA_FILL_EN
                        state_next = fill_reg ? ST_WR_REQ : ST_RD_REQ;
`else
                        state_next = ST_RD_REQ;
`endif
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset drops them at once.
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_DONE);
    assign err           = err_reg;
    assign mem_cmd_valid = (state_reg == ST_RD_REQ) || (state_reg == ST_WR_REQ);
    assign mem_cmd_wr    = (state_reg == ST_WR_REQ);
    assign mem_cmd_instr = 1'b0;
    assign mem_cmd_be    = BE_FULL;
    assign mem_cmd_addr  = (state_reg == ST_WR_REQ) ? dst_cur_reg :
                           (state_reg == ST_RD_REQ) ? src_cur_reg : 32'h0;
    assign mem_cmd_wdata = data_reg;

endmodule

// File: doc/bus_dma.md
Name: bus_dma

Overview:
- Bus initiator on the CPU memory bus (mem_cmd/mem_rsp protocol); the requester side of the interface the SoC decoder, local RAM and GPIO respond to.
- Copies a block of 32-bit words from a source address to a destination address.
- Issues word reads, waits for each read response, then issues the matching word write.
- Sits beside the CPU behind a bus arbiter; started and monitored through sideband control ports.

Parameters:
- LEN_BITS, 16: width of the word-count input.
- RSP_TIMEOUT, 255: cycles to wait for a read response before aborting with error.

Ports:
- clk  in  1  clock
- reset_  in  1  reset; one clock, asynchronous, active-low
- start  in  1  begin transfer; sampled in IDLE only
- src_addr  in  32  source byte address; bits [1:0] ignored
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- len_words  in  LEN_BITS  number of words to copy
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of transfer, including abort
- err  out  1  read-response timeout occurred; held until next accepted start
- mem_cmd_valid  out  1  command valid
- mem_cmd_ready  in  1  command accepted when valid && ready
- mem_cmd_wr  out  1  1 = write, 0 = read
- mem_cmd_instr  out  1  constant 0
- mem_cmd_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_cmd_wdata  out  32  write data
- mem_cmd_be  out  4  constant 4'hf
- mem_rsp_ready  in  1  read-response valid strobe
- mem_rsp_rdata  in  32  read data, valid with mem_rsp_ready

Behaviour:
- Reset values: state IDLE; busy, done, err, mem_cmd_valid, mem_cmd_wr = 0; addr/wdata = 0; counters = 0.
- Reset is asynchronous: mem_cmd_valid drops immediately, including mid-transfer.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - On start, latch src/dst with bits [1:0] cleared and latch len; clear err; busy=1.
  - len==0: go to DONE (no bus traffic). Otherwise go to RD_REQ.
  - start while busy is ignored.
- RD_REQ:
  - mem_cmd_valid=1, wr=0, addr=src_cur.
  - Valid/addr/wr stay stable until the handshake.
  - On handshake: clear timeout counter, go to RD_WAIT.
- RD_WAIT:
  - mem_cmd_valid=0.
  - On mem_rsp_ready: capture rdata into a data register, go to WR_REQ.
  - Otherwise increment the timeout counter. When it reaches RSP_TIMEOUT: set err=1, go to DONE, issue no write.
- WR_REQ:
  - mem_cmd_valid=1, wr=1, addr=dst_cur, wdata=captured data; all stable until handshake.
  - On handshake: src_cur+=4, dst_cur+=4, remaining-=1.
  - If remaining was 1, go to DONE; else go to RD_REQ.
- DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Address arithmetic: 32-bit, wraps modulo 2^32 (0xFFFFFFFC+4 = 0x0).
- Ordering: one outstanding read at most. mem_rsp_ready outside RD_WAIT is ignored.
- Latency: local RAM responds 2 cycles after cmd accept, so 4 cycles per word with ready=1.

Optional Feature:
- Macro BUS_DMA_FILL_EN.
- Defined:
  - Adds ports fill (in, 1) and fill_pattern (in, 32), both latched on start.
  - When fill=1, the block skips RD_REQ/RD_WAIT and writes fill_pattern to len consecutive words from dst.
  - A word costs 1 cycle when ready=1; err is never set.
- Undefined: ports absent; the block always copies.

Decomposition:
- Package bus_dma_pkg holds:
  - state encoding enum;
  - BE_FULL = 4'hf;
  - WORD_BYTES = 4.
- No sub-module; the timeout counter is inline.

Test Plan:
- Copy, normal case: start, src=0x100, dst=0x200, len=4, RAM model with latency 2 holding 0x11,0x22,0x33,0x44.
  - Reads at 0x100–0x10C; writes to 0x200–0x20C with the same data.
  - One done pulse, err=0, done 16–17 cycles after start.
- Zero length: len=0 -> done pulse within 2 cycles, mem_cmd_valid never high, busy low afterwards.
- Backpressure: mem_cmd_ready held low 3 cycles during WR_REQ -> addr/wdata/wr stable throughout, exactly one write accepted.
- Wrap and ignored start: src=0xFFFFFFFC, len=2 -> second read at 0x00000000; a start asserted during the transfer is ignored.
- Timeout: RSP_TIMEOUT=8, responder never answers -> err=1 and done 8 cycles after read accept, no write issued. Next start clears err.
- Reset mid-transfer: reset_ low during RD_WAIT -> valid/busy 0 immediately. After release, a new len=1 copy completes correctly.
